codec_intf: RTL and testbench

CODEC_INTF -- requirements
Module: codec_intf

---
 rtl/codec_intf.sv | 104 ++++++++++
 tb/tb_codec_intf.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/codec_intf.sv
// I2S codec bridge: derives MCLK/SCLK/LRCLK from one free-running counter,
// serialises the core's stereo pair to the DAC and deserialises the ADC stream.
module codec_intf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] lft_in,
  input  logic [15:0] rht_in,
  input  logic        SDout,
  output logic [15:0] lft_out,
  output logic [15:0] rht_out,
  output logic        valid,
  output logic        MCLK,
  output logic        SCLK,
  output logic        LRCLK,
  output logic        SDin,
  output logic        RSTn
);

  localparam logic [9:0] CNT_CAPTURE = 10'h010;
  localparam logic [9:0] CNT_LOAD    = 10'h01F;
  localparam logic [9:0] CNT_LAST    = 10'h3FF;
  localparam logic [1:0] FRM_READY   = 2'd2;

  logic [9:0]  clk_cnt;
  logic [31:0] rx;
  logic [31:0] tx;
  logic [1:0]  frm_cnt;

  logic sclk_rise;
  logic sclk_fall;
  logic at_capture;
  logic at_load;
  logic at_last;

  assign sclk_rise  = (clk_cnt[4:0] == 5'h0F);
  assign sclk_fall  = (clk_cnt[4:0] == 5'h1F);
  assign at_capture = (clk_cnt == CNT_CAPTURE);
  assign at_load    = (clk_cnt == CNT_LOAD);
  assign at_last    = (clk_cnt == CNT_LAST);

  // Codec clocks come straight from counter flops so they never glitch.
  assign MCLK  = clk_cnt[1];
  assign SCLK  = clk_cnt[4];
  assign LRCLK = clk_cnt[9];
  assign SDin  = tx[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 10'd1;
    end
  end

  // Receive: sample mid-bit on SCLK rising, MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx <= '0;
    end else if (sclk_rise) begin
      rx <= {rx[30:0], SDout};
    end
  end

  // By the capture point the last bit (right LSB, slot 0) has just been sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_out <= '0;
      rht_out <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= at_capture && (frm_cnt == FRM_READY);
      if (at_capture) begin
        lft_out <= rx[31:16];
        rht_out <= rx[15:0];
      end
    end
  end

  // Transmit: loading at the end of slot 0 gives the one-bit I2S delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx <= '0;
    end else if (at_load) begin
      tx <= {lft_in, rht_in};
    end else if (sclk_fall) begin
      tx <= {tx[30:0], 1'b0};
    end
  end

  // Startup: release the codec after one frame, then wait two more frames
  // before trusting captured samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RSTn    <= 1'b0;
      frm_cnt <= '0;
    end else if (at_last) begin
      RSTn <= 1'b1;
      if (RSTn && (frm_cnt != FRM_READY)) begin
        frm_cnt <= frm_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_codec_intf.sv
// Bench for codec_intf: randomized stereo stimulus, loopback and fixed ADC
// patterns, checked every cycle against a frame-level reference model.
module tb_codec_intf;

  logic        clk;
  logic        rst_n;
  logic [15:0] lft_in;
  logic [15:0] rht_in;
  logic        SDout;
  logic [15:0] lft_out;
  logic [15:0] rht_out;
  logic        valid;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        SDin;
  logic        RSTn;

  // 0 = loopback, 1 = ADC held 0, 2 = ADC held 1, 3 = random ADC bits
  int          mode;
  logic        drv_bit;

  int          n_tests;
  int          n_fail;

  // reference model state
  int          cyc;        // edges since reset release
  logic [31:0] word;       // pair most recently latched for transmission
  logic [31:0] exp_pair;   // pair expected on lft_out/rht_out
  logic        exp_q[$];   // bits the DUT sampled, oldest first

  codec_intf dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .lft_in  (lft_in),
    .rht_in  (rht_in),
    .SDout   (SDout),
    .lft_out (lft_out),
    .rht_out (rht_out),
    .valid   (valid),
    .MCLK    (MCLK),
    .SCLK    (SCLK),
    .LRCLK   (LRCLK),
    .SDin    (SDin),
    .RSTn    (RSTn)
  );

  assign SDout = (mode == 0) ? SDin : drv_bit;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic exp_serial_bit(input int c);
    int slot;
    slot = c / 32;
    if (slot == 0) return word[0];
    return word[32 - slot];
  endfunction

  // Called at a negedge; asserts reset immediately and releases at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_lft",   32'(lft_out), 32'h0);
    check("rst_rht",   32'(rht_out), 32'h0);
    check("rst_valid", 32'(valid),   32'h0);
    check("rst_mclk",  32'(MCLK),    32'h0);
    check("rst_sclk",  32'(SCLK),    32'h0);
    check("rst_lrclk", 32'(LRCLK),   32'h0);
    check("rst_sdin",  32'(SDin),    32'h0);
    check("rst_rstn",  32'(RSTn),    32'h0);
    repeat (3) @(negedge clk);
    cyc      = 0;
    word     = '0;
    exp_pair = '0;
    exp_q.delete();
    rst_n    = 1'b1;
  endtask

  // One clock: check outputs for the current edge count, drive inputs,
  // advance the model across the coming rising edge, then wait for the next negedge.
  task automatic step(input logic [15:0] l, input logic [15:0] r, input int m);
    int          c;
    logic [9:0]  cc;
    logic        sbit;
    logic        b;
    logic [31:0] v;
    c    = cyc % 1024;
    cc   = 10'(c);
    sbit = exp_serial_bit(c);

    check("mclk",  32'(MCLK),  32'(cc[1]));
    check("sclk",  32'(SCLK),  32'(cc[4]));
    check("lrclk", 32'(LRCLK), 32'(cc[9]));
    check("sdin",  32'(SDin),  32'(sbit));
    check("rstn",  32'(RSTn),  32'(cyc >= 1024));
    check("valid", 32'(valid), 32'((cyc >= 3089) && (c == 17)));
    if (c == 17) begin
      check("lft_out", 32'(lft_out), 32'(exp_pair[31:16]));
      check("rht_out", 32'(rht_out), 32'(exp_pair[15:0]));
    end

    lft_in = l;
    rht_in = r;
    mode   = m;
    case (m)
      1:       drv_bit = 1'b0;
      2:       drv_bit = 1'b1;
      3:       drv_bit = 1'($urandom_range(0, 1));
      default: drv_bit = 1'b0;
    endcase
    b = (m == 0) ? sbit : drv_bit;

    if (c % 32 == 15) begin
      exp_q.push_back(b);
      if (exp_q.size() > 32) void'(exp_q.pop_front());
    end
    if (c == 16) begin
      v = '0;
      foreach (exp_q[i]) v = {v[30:0], exp_q[i]};
      exp_pair = v;
    end
    if (c == 31) word = {l, r};
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] l;
    logic [15:0] r;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    lft_in  = '0;
    rht_in  = '0;
    mode    = 0;
    drv_bit = 1'b0;
    cyc     = 0;
    word    = '0;
    exp_pair = '0;

    @(negedge clk);
    do_reset();

    // loopback with a fixed pair through startup and two valid frames
    repeat (4200) step(16'h1234, 16'hABCD, 0);

    // change the pair at a non-load point mid-frame
    while (cyc % 1024 != 500) step(16'h1234, 16'hABCD, 0);
    repeat (2100) step(16'h8001, 16'h7FFE, 0);

    // loopback with pairs changing at random instants
    l = 16'($urandom);
    r = 16'($urandom);
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0) begin
        l = 16'($urandom);
        r = 16'($urandom);
      end
      step(l, r, 0);
    end

    // fixed and random ADC streams, DAC side still fed
    repeat (1100) step(16'h5A5A, 16'hC3C3, 2);
    repeat (1100) step(16'h5A5A, 16'hC3C3, 1);
    repeat (1100) step(16'($urandom), 16'($urandom), 3);

    // reset during steady operation, then restart with ADC held high
    while (cyc % 1024 != 10'h200) step(16'h1111, 16'h2222, 0);
    do_reset();
    repeat (3200) step(16'h1111, 16'h2222, 2);
    repeat (2100) step(16'h0F0F, 16'hF0F0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
